// File: rtl/exception_ctrl.sv
// Commit-stage exception arbiter. It merges the per-slot exception vectors and pending
// interrupts into one prioritised event, then sequences a pipeline flush and a PC redirect.
//
// state    | meaning
// IDLE     | accepting commit slots, exception_* outputs live
// FLUSH    | flush_o high, down-counter runs to terminal count 1
// REDIRECT | new_pc offered to fetch until new_pc_ready_i
module exception_ctrl #(
  parameter int          FLUSH_CYCLES = 2,
  parameter logic [31:0] EXC_OFFSET   = 32'h180,
  parameter logic [4:0]  ERET_CODE    = 5'h0E
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        valid1_i,
  input  logic        valid2_i,
  input  logic [8:0]  excp1_i,
  input  logic [8:0]  excp2_i,
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  input  logic [31:0] epc_i,
  input  logic [31:0] ebase_i,
  input  logic        new_pc_ready_i,
  output logic        exception_flag_o,
  output logic [4:0]  exception_type_o,
  output logic        exception_first_inst_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        new_pc_valid_o,
  output logic        busy_o
);

  localparam int CW = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, FLUSH, REDIRECT} state_t;

  state_t      state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [31:0] target, target_nxt;

  logic        int_pend;
  logic        hit1, hit2, eret1, eret2;
  logic [4:0]  code1, code2;
  logic        ev1, ev2, take, take_eret;
  logic [4:0]  take_code;

  logic unused_cp0_bits;
  assign unused_cp0_bits = ^{status_i[31:16], status_i[7:2], cause_i[31:16], cause_i[7:0]};

  // Returns {eret_only, hit, code}; ERET only counts when no other bit in the slot is set.
  function automatic logic [6:0] decode(input logic [8:0] e);
    logic [4:0] c;
    logic       h;
    c = 5'd0;
    h = 1'b1;
    if      (e[0]) c = 5'd4;
    else if (e[1]) c = 5'd10;
    else if (e[2]) c = 5'd12;
    else if (e[3]) c = 5'd13;
    else if (e[4]) c = 5'd8;
    else if (e[5]) c = 5'd9;
    else if (e[6]) c = 5'd4;
    else if (e[7]) c = 5'd5;
    else if (e[8]) c = ERET_CODE;
    else           h = 1'b0;
    return {e[8] & ~|e[7:0], h, c};
  endfunction

  assign int_pend = status_i[0] & ~status_i[1] & |(status_i[15:8] & cause_i[15:8]);

  always_comb begin
    {eret1, hit1, code1} = decode(excp1_i);
    {eret2, hit2, code2} = decode(excp2_i);
    // An interrupt overrides whatever the slot it attaches to carries.
    ev1 = valid1_i & (int_pend | hit1);
    ev2 = valid2_i & (int_pend | hit2);
    take      = (ev1 | ev2) & ~resetn;
    take_code = int_pend ? 5'd0 : (ev1 ? code1 : code2);
    take_eret = ~int_pend & (ev1 ? eret1 : eret2);
  end

  always_comb begin
    state_nxt              = state;
    cnt_nxt                = cnt;
    target_nxt             = target;
    exception_flag_o       = 1'b0;
    exception_type_o       = 5'd0;
    exception_first_inst_o = 1'b0;
    flush_o                = 1'b0;
    new_pc_o               = 32'd0;
    new_pc_valid_o         = 1'b0;
    busy_o                 = 1'b1;
    case (state)
      IDLE: begin
        busy_o = 1'b0;
        if (take) begin
          exception_flag_o       = 1'b1;
          exception_type_o       = take_code;
          exception_first_inst_o = ev1;
          state_nxt              = FLUSH;
          cnt_nxt                = CW'(FLUSH_CYCLES);
          target_nxt             = take_eret ? epc_i : ebase_i + EXC_OFFSET;
        end
      end
      FLUSH: begin
        flush_o = 1'b1;
        cnt_nxt = cnt - CW'(1);
        if (cnt == CW'(1)) state_nxt = REDIRECT;
      end
      REDIRECT: begin
        new_pc_valid_o = 1'b1;
        new_pc_o       = target;
        if (new_pc_ready_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      state  <= IDLE;
      cnt    <= '0;
      target <= 32'd0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      target <= target_nxt;
    end
  end

endmodule

// File: tb/tb_exception_ctrl.sv
// Bench for exception_ctrl: direct checks of the commit-cycle outputs plus a scoreboard
// of redirect targets pushed when an exception is presented and popped when fetch sees it.
module tb_exception_ctrl;

  logic        clk, resetn;
  logic        valid1_i, valid2_i;
  logic [8:0]  excp1_i, excp2_i;
  logic [31:0] status_i, cause_i, epc_i, ebase_i;
  logic        new_pc_ready_i;
  logic        exception_flag_o;
  logic [4:0]  exception_type_o;
  logic        exception_first_inst_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        new_pc_valid_o;
  logic        busy_o;

  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0] exp_pc_q[$];

  exception_ctrl dut (
    .clk(clk), .resetn(resetn),
    .valid1_i(valid1_i), .valid2_i(valid2_i),
    .excp1_i(excp1_i), .excp2_i(excp2_i),
    .status_i(status_i), .cause_i(cause_i), .epc_i(epc_i), .ebase_i(ebase_i),
    .new_pc_ready_i(new_pc_ready_i),
    .exception_flag_o(exception_flag_o), .exception_type_o(exception_type_o),
    .exception_first_inst_o(exception_first_inst_o),
    .flush_o(flush_o), .new_pc_o(new_pc_o), .new_pc_valid_o(new_pc_valid_o),
    .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_commit();
    valid1_i = 1'b0; valid2_i = 1'b0;
    excp1_i  = 9'd0; excp2_i  = 9'd0;
    status_i = 32'd0; cause_i = 32'd0;
  endtask

  task automatic drive(input logic v1, input logic [8:0] e1, input logic v2, input logic [8:0] e2,
                       input logic [31:0] st, input logic [31:0] ca,
                       input logic [31:0] epc, input logic [31:0] eb);
    valid1_i = v1; excp1_i = e1; valid2_i = v2; excp2_i = e2;
    status_i = st; cause_i = ca; epc_i = epc; ebase_i = eb;
  endtask

  // Full exception: commit cycle, flush window, redirect held ready_delay cycles, then
  // either accepted by fetch or killed by reset.
  task automatic exc_seq(input string tag,
                         input logic v1, input logic [8:0] e1, input logic v2, input logic [8:0] e2,
                         input logic [31:0] st, input logic [31:0] ca,
                         input logic [31:0] epc, input logic [31:0] eb,
                         input logic [4:0] exp_type, input logic exp_first, input logic [31:0] exp_pc,
                         input int ready_delay, input bit use_reset, input bit inject);
    logic [31:0] sb_pc;
    advance();
    drive(v1, e1, v2, e2, st, ca, epc, eb);
    new_pc_ready_i = 1'b0;
    @(negedge clk);
    chk({tag, ".flag"}, 32'(exception_flag_o), 32'd1);
    chk({tag, ".type"}, 32'(exception_type_o), 32'(exp_type));
    chk({tag, ".first"}, 32'(exception_first_inst_o), 32'(exp_first));
    exp_pc_q.push_back(exp_pc);
    advance();
    if (inject) drive(1'b1, 9'h010, 1'b0, 9'd0, 32'd0, 32'd0, 32'h0BAD0000, 32'h0BAD0000);
    else clear_commit();
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      chk($sformatf("%s.flush%0d", tag, i), 32'(flush_o), 32'd1);
      chk($sformatf("%s.noflag%0d", tag, i), 32'(exception_flag_o), 32'd0);
      chk($sformatf("%s.novalid%0d", tag, i), 32'(new_pc_valid_o), 32'd0);
      advance();
      if (!inject || i == 2) clear_commit();
    end
    @(negedge clk);
    chk({tag, ".flush_end"}, 32'(flush_o), 32'd0);
    chk({tag, ".pc_valid"}, 32'(new_pc_valid_o), 32'd1);
    if (exp_pc_q.size() == 0) begin
      chk({tag, ".sb_empty"}, 32'd0, 32'd1);
      sb_pc = 32'hxxxxxxxx;
    end else begin
      sb_pc = exp_pc_q.pop_front();
    end
    chk({tag, ".pc"}, new_pc_o, sb_pc);
    if (sb_pc != eb + 32'h180) chk({tag, ".not_ebase"}, 32'(new_pc_o == eb + 32'h180), 32'd0);
    for (int d = 0; d < ready_delay; d++) begin
      advance();
      @(negedge clk);
      chk($sformatf("%s.hold_valid%0d", tag, d), 32'(new_pc_valid_o), 32'd1);
      chk($sformatf("%s.hold_pc%0d", tag, d), new_pc_o, sb_pc);
    end
    advance();
    if (use_reset) resetn = 1'b1;
    else new_pc_ready_i = 1'b1;
    @(negedge clk);
    chk({tag, ".busy_last"}, 32'(busy_o), 32'd1);
    advance();
    resetn = 1'b0;
    new_pc_ready_i = 1'b0;
    @(negedge clk);
    chk({tag, ".done_busy"}, 32'(busy_o), 32'd0);
    chk({tag, ".done_valid"}, 32'(new_pc_valid_o), 32'd0);
    chk({tag, ".done_pc"}, new_pc_o, 32'd0);
  endtask

  task automatic no_event(input string tag,
                          input logic v1, input logic [8:0] e1, input logic v2, input logic [8:0] e2,
                          input logic [31:0] st, input logic [31:0] ca, input bit with_reset);
    advance();
    drive(v1, e1, v2, e2, st, ca, 32'h0, 32'hBFC00200);
    if (with_reset) resetn = 1'b1;
    @(negedge clk);
    chk({tag, ".flag"}, 32'(exception_flag_o), 32'd0);
    advance();
    clear_commit();
    resetn = 1'b0;
    @(negedge clk);
    chk({tag, ".busy"}, 32'(busy_o), 32'd0);
    chk({tag, ".flush"}, 32'(flush_o), 32'd0);
  endtask

  initial begin
    resetn = 1'b1;
    new_pc_ready_i = 1'b0;
    epc_i = 32'd0; ebase_i = 32'd0;
    clear_commit();
    repeat (2) advance();
    @(negedge clk);
    chk("rst.flag", 32'(exception_flag_o), 32'd0);
    chk("rst.busy", 32'(busy_o), 32'd0);
    chk("rst.flush", 32'(flush_o), 32'd0);
    chk("rst.valid", 32'(new_pc_valid_o), 32'd0);
    chk("rst.pc", new_pc_o, 32'd0);
    advance();
    resetn = 1'b0;

    exc_seq("sys_slot2", 1'b1, 9'h000, 1'b1, 9'h010, 32'd0, 32'd0, 32'h0, 32'hBFC00200,
            5'd8, 1'b0, 32'hBFC00380, 2, 1'b0, 1'b0);
    exc_seq("ov_over_ades", 1'b1, 9'h004, 1'b1, 9'h080, 32'd0, 32'd0, 32'h0, 32'hBFC00200,
            5'd12, 1'b1, 32'hBFC00380, 0, 1'b0, 1'b0);
    exc_seq("int_slot1", 1'b1, 9'h000, 1'b0, 9'h000, 32'h00000401, 32'h00000400, 32'h0, 32'hBFC00200,
            5'd0, 1'b1, 32'hBFC00380, 1, 1'b0, 1'b0);
    no_event("int_exl", 1'b1, 9'h000, 1'b0, 9'h000, 32'h00000403, 32'h00000400, 1'b0);
    exc_seq("int_slot2", 1'b0, 9'h000, 1'b1, 9'h000, 32'h00000401, 32'h00000400, 32'h0, 32'hBFC00200,
            5'd0, 1'b0, 32'hBFC00380, 0, 1'b0, 1'b0);
    no_event("int_noslot", 1'b0, 9'h000, 1'b0, 9'h000, 32'h00000401, 32'h00000400, 1'b0);
    exc_seq("int_over_ri", 1'b1, 9'h002, 1'b0, 9'h000, 32'h00008001, 32'h00008000, 32'h0, 32'hBFC00200,
            5'd0, 1'b1, 32'hBFC00380, 0, 1'b0, 1'b0);
    exc_seq("eret", 1'b1, 9'h100, 1'b0, 9'h000, 32'd0, 32'd0, 32'h80001234, 32'hBFC00200,
            5'h0E, 1'b1, 32'h80001234, 0, 1'b0, 1'b0);
    exc_seq("hold_reset", 1'b1, 9'h020, 1'b0, 9'h000, 32'd0, 32'd0, 32'h0, 32'h80000000,
            5'd9, 1'b1, 32'h80000180, 10, 1'b1, 1'b0);
    exc_seq("inject_flush", 1'b1, 9'h008, 1'b0, 9'h000, 32'd0, 32'd0, 32'h0, 32'h9FC00000,
            5'd13, 1'b1, 32'h9FC00180, 0, 1'b0, 1'b1);
    exc_seq("adelmem_ades", 1'b1, 9'h0C0, 1'b0, 9'h000, 32'd0, 32'd0, 32'h0, 32'hBFC00200,
            5'd4, 1'b1, 32'hBFC00380, 0, 1'b0, 1'b0);
    exc_seq("slot1_invalid", 1'b0, 9'h002, 1'b1, 9'h020, 32'd0, 32'd0, 32'h0, 32'hFFFFFF00,
            5'd9, 1'b0, 32'h00000080, 0, 1'b0, 1'b0);
    exc_seq("adelif_eret", 1'b0, 9'h000, 1'b1, 9'h101, 32'd0, 32'd0, 32'h80005555, 32'hBFC00200,
            5'd4, 1'b0, 32'hBFC00380, 0, 1'b0, 1'b0);
    no_event("reset_wins", 1'b1, 9'h010, 1'b0, 9'h000, 32'd0, 32'd0, 1'b1);
    no_event("eret_invalid", 1'b0, 9'h100, 1'b0, 9'h004, 32'd0, 32'd0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
